// File: rtl/bnn_pkg.sv
// Shared types and default geometry for the binary-neuron parameter loader.
package bnn_pkg;

  localparam int NEURONS        = 8;
  localparam int INPUTS         = 8;
  localparam int BIAS_BITS      = 3;
  localparam int DEF_CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bnn_readback_packer.sv
// Serial-to-byte packer: collects chain tail bits MSB-first and emits a byte
// every DATA_W samples, or a left-aligned zero-padded partial byte on flush.
module bnn_readback_packer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample,
  input  logic              bit_in,
  input  logic              flush,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int NW = $clog2(DATA_W);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [NW-1:0]     n;

  assign acc_nxt = {acc[DATA_W-2:0], bit_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      n        <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (sample) begin
        if ((n == NW'(DATA_W - 1)) || flush) begin
          // only the low n+1 bits carry samples; shift them up to the MSB
          rb_data  <= acc_nxt << (NW'(DATA_W - 1) - n);
          rb_valid <= 1'b1;
          acc      <= '0;
          n        <= '0;
        end else begin
          acc <= acc_nxt;
          n   <= n + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bnn_param_loader.sv
// Bit-serial configuration sequencer for the binary-neuron scan chain.
// Optional chain readback is built when BNN_LOADER_READBACK_EN is defined.
module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int CHAIN_BITS = DEF_CHAIN_BITS,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              setup,
  output logic              param_out,
  input  logic              chain_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int              CNT_W    = $clog2(CHAIN_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_BITS - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        bcnt, bcnt_nxt;
  logic              setup_nxt, param_nxt;
  logic              last_bit;

  assign last_bit = (cnt == LAST_BIT);
  assign in_ready = (state == FETCH);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      setup     <= 1'b0;
      param_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      bcnt      <= bcnt_nxt;
      setup     <= setup_nxt;
      param_out <= param_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bcnt_nxt  = bcnt;
    setup_nxt = 1'b0;
    param_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        if (in_valid) begin
          state_nxt = SHIFT;
          sr_nxt    = {in_data[DATA_W-2:0], 1'b0};
          bcnt_nxt  = '0;
          setup_nxt = 1'b1;
          param_nxt = in_data[DATA_W-1];
        end
      end
      SHIFT: begin
        // the bit on param_out transfers at this edge; last_bit also trims a short final byte
        cnt_nxt  = cnt + 1'b1;
        bcnt_nxt = bcnt + 3'd1;
        if (last_bit) begin
          state_nxt = DONE;
        end else if (bcnt == 3'd7) begin
          state_nxt = FETCH;
        end else begin
          setup_nxt = 1'b1;
          param_nxt = sr[DATA_W-1];
          sr_nxt    = {sr[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef BNN_LOADER_READBACK_EN
  bnn_readback_packer #(
    .DATA_W (DATA_W)
  ) u_readback (
    .clk      (clk),
    .reset    (reset),
    .sample   (setup),
    .bit_in   (chain_in),
    .flush    (setup && last_bit),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );
`else
  logic unused_chain_in;
  assign unused_chain_in = chain_in;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: 88-bit default chain and an 11-bit single-neuron chain.
module tb_bnn_param_loader;
  import bnn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // 88-bit chain DUT
  logic       start88 = 1'b0, in_valid88 = 1'b0;
  logic [7:0] in_data88 = '0;
  logic       in_ready88, setup88, param_out88, chain_in88, busy88, done88, rb_valid88;
  logic [7:0] rb_data88;
  logic [87:0] chain88 = '0;
  logic [7:0] rbq88[$];

  bnn_param_loader #(.CHAIN_BITS(88)) u_dut88 (
    .clk(clk), .reset(reset), .start(start88), .in_data(in_data88), .in_valid(in_valid88),
    .in_ready(in_ready88), .setup(setup88), .param_out(param_out88), .chain_in(chain_in88),
    .busy(busy88), .done(done88), .rb_data(rb_data88), .rb_valid(rb_valid88)
  );

  assign chain_in88 = chain88[87];
  always @(posedge clk) if (setup88) chain88 <= {chain88[86:0], param_out88};
  always @(negedge clk) if (rb_valid88) rbq88.push_back(rb_data88);

  // 11-bit single-neuron DUT
  logic       start11 = 1'b0, in_valid11 = 1'b0;
  logic [7:0] in_data11 = '0;
  logic       in_ready11, setup11, param_out11, chain_in11, busy11, done11, rb_valid11;
  logic [7:0] rb_data11;
  logic [10:0] chain11 = '0;
  logic [7:0] rbq11[$];

  bnn_param_loader #(.CHAIN_BITS(11)) u_dut11 (
    .clk(clk), .reset(reset), .start(start11), .in_data(in_data11), .in_valid(in_valid11),
    .in_ready(in_ready11), .setup(setup11), .param_out(param_out11), .chain_in(chain_in11),
    .busy(busy11), .done(done11), .rb_data(rb_data11), .rb_valid(rb_valid11)
  );

  assign chain_in11 = chain11[10];
  always @(posedge clk) if (setup11) chain11 <= {chain11[9:0], param_out11};
  always @(negedge clk) if (rb_valid11) rbq11.push_back(rb_data11);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] pack88(input logic [7:0] b[11]);
    logic [87:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[79:0], b[i]};
    return r;
  endfunction

  function automatic logic [87:0] packq(input logic [7:0] q[$]);
    logic [87:0] r;
    r = '0;
    for (int i = 0; i < q.size() && i < 11; i++) r = {r[79:0], q[i]};
    return r;
  endfunction

  // One load on the 88-bit DUT; optional stall before byte stall_idx and optional ignored starts.
  task automatic load88(input logic [7:0] b[11], input int stall_idx, input int stall_len,
                        input bit poke, output int lat, output int scyc, output int dcnt,
                        output logic busy_after);
    int  idx, stall;
    bit  fin;
    idx = 0; stall = stall_len; scyc = 0; dcnt = 0; lat = -1; fin = 0;
    rbq88.delete();
    @(negedge clk);
    start88 = 1'b1;
    in_valid88 = 1'b0;
    for (int n = 1; n < 300 && !fin; n++) begin
      @(negedge clk);
      start88 = 1'b0;
      if (setup88) scyc++;
      if (done88) begin
        dcnt++; lat = n; fin = 1;
        if (poke) start88 = 1'b1;
      end
      if (poke && n == 30) start88 = 1'b1;
      in_valid88 = 1'b0;
      if (in_ready88 && idx < 11) begin
        if (idx == stall_idx && stall > 0) begin
          stall--;
          check("stall_setup", setup88, 1'b0);
        end else begin
          in_valid88 = 1'b1;
          in_data88  = b[idx];
          idx++;
        end
      end
    end
    @(negedge clk);
    start88 = 1'b0;
    in_valid88 = 1'b0;
    busy_after = busy88;
    for (int n = 0; n < 3; n++) begin
      if (setup88) scyc++;
      if (done88) dcnt++;
      @(negedge clk);
    end
  endtask

  task automatic load11(input logic [7:0] b0, input logic [7:0] b1,
                        output int lat, output int scyc, output int dcnt);
    int idx;
    bit fin;
    idx = 0; scyc = 0; dcnt = 0; lat = -1; fin = 0;
    rbq11.delete();
    @(negedge clk);
    start11 = 1'b1;
    for (int n = 1; n < 60 && !fin; n++) begin
      @(negedge clk);
      start11 = 1'b0;
      if (setup11) scyc++;
      if (done11) begin dcnt++; lat = n; fin = 1; end
      in_valid11 = 1'b0;
      if (in_ready11 && idx < 2) begin
        in_valid11 = 1'b1;
        in_data11  = (idx == 0) ? b0 : b1;
        idx++;
      end
    end
    in_valid11 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (setup11) scyc++;
      if (done11) dcnt++;
    end
  endtask

  logic [7:0] p1[11] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hA5, 8'hC3};
  logic [7:0] p2[11] = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h81, 8'h7E, 8'h3C, 8'hC3, 8'h01, 8'h80, 8'h5A};

  initial begin
    int   lat, scyc, dcnt, dseen;
    logic busy_after;

    // reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_setup", setup88, 1'b0);
    check("rst_param_out", param_out88, 1'b0);
    check("rst_in_ready", in_ready88, 1'b0);
    check("rst_busy", busy88, 1'b0);
    check("rst_done", done88, 1'b0);
    check("rst_rb_data", rb_data88, 8'h00);
    check("rst_rb_valid", rb_valid88, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy88, 1'b0);

    // zero-wait default chain
    load88(p1, -1, 0, 1'b0, lat, scyc, dcnt, busy_after);
    check("p1_latency", lat, 100);
    check("p1_setup_cycles", scyc, 88);
    check("p1_done_pulses", dcnt, 1);
    check("p1_chain", chain88, pack88(p1));
`ifdef BNN_LOADER_READBACK_EN
    check("p1_rb_count", rbq88.size(), 11);
    check("p1_rb_data", packq(rbq88), 88'h0);
`else
    check("p1_rb_count", rbq88.size(), 0);
`endif

    // five-cycle stall before the third byte
    load88(p2, 2, 5, 1'b0, lat, scyc, dcnt, busy_after);
    check("stall_latency", lat, 105);
    check("stall_setup_cycles", scyc, 88);
    check("stall_done_pulses", dcnt, 1);
    check("stall_chain", chain88, pack88(p2));
`ifdef BNN_LOADER_READBACK_EN
    check("p2_rb_count", rbq88.size(), 11);
    check("p2_rb_data", packq(rbq88), pack88(p1));
`endif

    // start pulses while busy and in the DONE cycle are ignored
    load88(p1, -1, 0, 1'b1, lat, scyc, dcnt, busy_after);
    check("poke_latency", lat, 100);
    check("poke_setup_cycles", scyc, 88);
    check("poke_done_pulses", dcnt, 1);
    check("poke_busy_after", busy_after, 1'b0);
    check("poke_chain", chain88, pack88(p1));
`ifdef BNN_LOADER_READBACK_EN
    check("poke_rb_data", packq(rbq88), pack88(p2));
`endif

    // reset during the fourth byte
    @(negedge clk);
    start88 = 1'b1;
    @(negedge clk);
    start88 = 1'b0;
    in_valid88 = 1'b1;
    in_data88 = 8'h3C;
    for (int n = 0; n < 32; n++) @(negedge clk);
    check("mid_setup_before", setup88, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_setup_drop", setup88, 1'b0);
    check("mid_busy_drop", busy88, 1'b0);
    check("mid_in_ready_drop", in_ready88, 1'b0);
    dseen = 0;
    in_valid88 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done88) dseen++;
      if (n == 1) reset = 1'b0;
    end
    check("mid_no_done", dseen, 0);
    load88(p2, -1, 0, 1'b0, lat, scyc, dcnt, busy_after);
    check("reload_latency", lat, 100);
    check("reload_chain", chain88, pack88(p2));

    // single-neuron chain: bias 3'b101, weights 8'h2F
    load11(8'hA5, 8'hE0, lat, scyc, dcnt);
    check("n1_latency", lat, 14);
    check("n1_setup_cycles", scyc, 11);
    check("n1_done_pulses", dcnt, 1);
    check("n1_bias", chain11[10:8], 3'b101);
    check("n1_weights", chain11[7:0], 8'h2F);

    // low bits of the short final byte are dropped: bias 3'b010, weights 8'hD0
    load11(8'h5A, 8'h1F, lat, scyc, dcnt);
    check("n2_setup_cycles", scyc, 11);
    check("n2_bias", chain11[10:8], 3'b010);
    check("n2_weights", chain11[7:0], 8'hD0);
`ifdef BNN_LOADER_READBACK_EN
    check("n2_rb_count", rbq11.size(), 2);
    if (rbq11.size() == 2) begin
      check("n2_rb_byte0", rbq11[0], 8'hA5);
      check("n2_rb_byte1", rbq11[1], 8'hE0);
    end
`else
    check("n2_rb_count", rbq11.size(), 0);
    check("n2_rb_data_tied", rb_data11, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
